// File: rtl/flappy_vga_renderer.sv
// Flappy VGA renderer: 640x480@60 timing, bird box plus N_PIPES gapped pipes, 2-stage colour pipeline.
// Define FLAPPY_COLLIDE_EN to build the per-frame bird/pipe collision flag; otherwise collide is tied 0.
module flappy_vga_renderer #(
  parameter int CLK_DIV     = 4,
  parameter int COORD_W     = 10,
  parameter int N_PIPES     = 4,
  parameter int BIRD_HALF   = 10,
  parameter int PIPE_HALF_W = 20,
  parameter int GAP_HALF    = 50,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic                         ClkPort,
  input  logic                         reset,
  input  logic [COORD_W-1:0]           bird_x,
  input  logic [COORD_W-1:0]           bird_y,
  input  logic [N_PIPES*COORD_W-1:0]   pipe_x,
  input  logic [N_PIPES*COORD_W-1:0]   gap_y,
  input  logic [N_PIPES-1:0]           pipe_en,
  output logic                         vga_h_sync,
  output logic                         vga_v_sync,
  output logic                         vga_r,
  output logic                         vga_g,
  output logic                         vga_b,
  output logic                         frame_start,
  output logic                         collide
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW1     = COORD_W + 1;

  logic [DIV_W-1:0]           r_div;
  logic [COORD_W-1:0]         r_hcnt, r_vcnt;
  logic [COORD_W-1:0]         r_bird_x, r_bird_y;
  logic [N_PIPES*COORD_W-1:0] r_pipe_x, r_gap_y;
  logic [N_PIPES-1:0]         r_pipe_en;
  logic r_bird1, r_pipe1, r_vis1, r_hs1, r_vs1;
  logic w_pix_en, w_latch, w_vis0, w_hs0, w_vs0, w_bird_hit, w_pipe_hit;
  logic [CW1-1:0] w_x, w_y;

  assign w_pix_en = (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge ClkPort) begin
    if (reset || w_pix_en) r_div <= '0;
    else                   r_div <= r_div + 1'b1;
  end

  always_ff @(posedge ClkPort) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_pix_en) begin
      if (r_hcnt == COORD_W'(H_TOTAL - 1)) begin
        r_hcnt <= '0;
        r_vcnt <= (r_vcnt == COORD_W'(V_TOTAL - 1)) ? '0 : r_vcnt + 1'b1;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  assign w_vis0 = (r_hcnt < COORD_W'(H_ACTIVE)) && (r_vcnt < COORD_W'(V_ACTIVE));
  assign w_hs0  = !((r_hcnt >= COORD_W'(H_ACTIVE + H_FP)) && (r_hcnt < COORD_W'(H_ACTIVE + H_FP + H_SYNC)));
  assign w_vs0  = !((r_vcnt >= COORD_W'(V_ACTIVE + V_FP)) && (r_vcnt < COORD_W'(V_ACTIVE + V_FP + V_SYNC)));
  assign w_latch = w_pix_en && (r_hcnt == '0) && (r_vcnt == COORD_W'(V_ACTIVE));
  assign frame_start = w_latch;

  // Coordinates are only sampled at the top of vblank so a frame never tears.
  always_ff @(posedge ClkPort) begin
    if (reset) begin
      r_bird_x  <= '0;
      r_bird_y  <= '0;
      r_pipe_x  <= '0;
      r_gap_y   <= '0;
      r_pipe_en <= '0;
    end else if (w_latch) begin
      r_bird_x  <= bird_x;
      r_bird_y  <= bird_y;
      r_pipe_x  <= pipe_x;
      r_gap_y   <= gap_y;
      r_pipe_en <= pipe_en;
    end
  end

  // Offsets are added to the counter side so objects near 0 never wrap.
  assign w_x = {1'b0, r_hcnt};
  assign w_y = {1'b0, r_vcnt};

  always_comb begin
    w_bird_hit = (w_x + CW1'(BIRD_HALF) >= {1'b0, r_bird_x}) && (w_x <= {1'b0, r_bird_x} + CW1'(BIRD_HALF))
              && (w_y + CW1'(BIRD_HALF) >= {1'b0, r_bird_y}) && (w_y <= {1'b0, r_bird_y} + CW1'(BIRD_HALF));
    w_pipe_hit = 1'b0;
    for (int i = 0; i < N_PIPES; i++) begin
      if (r_pipe_en[i]
          && (w_x + CW1'(PIPE_HALF_W) >= {1'b0, r_pipe_x[i*COORD_W +: COORD_W]})
          && (w_x <= {1'b0, r_pipe_x[i*COORD_W +: COORD_W]} + CW1'(PIPE_HALF_W))
          && ((w_y + CW1'(GAP_HALF) < {1'b0, r_gap_y[i*COORD_W +: COORD_W]})
              || (w_y > {1'b0, r_gap_y[i*COORD_W +: COORD_W]} + CW1'(GAP_HALF))))
        w_pipe_hit = 1'b1;
    end
  end

  always_ff @(posedge ClkPort) begin
    if (reset) begin
      r_bird1    <= 1'b0;
      r_pipe1    <= 1'b0;
      r_vis1     <= 1'b0;
      r_hs1      <= 1'b1;
      r_vs1      <= 1'b1;
      vga_r      <= 1'b0;
      vga_g      <= 1'b0;
      vga_b      <= 1'b0;
      vga_h_sync <= 1'b1;
      vga_v_sync <= 1'b1;
    end else if (w_pix_en) begin
      r_bird1    <= w_bird_hit;
      r_pipe1    <= w_pipe_hit;
      r_vis1     <= w_vis0;
      r_hs1      <= w_hs0;
      r_vs1      <= w_vs0;
      vga_r      <= r_bird1 & r_vis1;
      vga_g      <= r_pipe1 & r_vis1;
      vga_b      <= ~(r_bird1 | r_pipe1) & r_vis1;
      vga_h_sync <= r_hs1;
      vga_v_sync <= r_vs1;
    end
  end

`ifdef FLAPPY_COLLIDE_EN
  logic r_hit_flag, r_collide, w_hit;
  assign w_hit = r_bird1 & r_pipe1 & r_vis1;

  // A hit landing on the frame_start cycle belongs to the frame that is just beginning.
  always_ff @(posedge ClkPort) begin
    if (reset) begin
      r_hit_flag <= 1'b0;
      r_collide  <= 1'b0;
    end else if (w_latch) begin
      r_collide  <= r_hit_flag;
      r_hit_flag <= w_hit;
    end else if (w_hit) begin
      r_hit_flag <= 1'b1;
    end
  end
  assign collide = r_collide;
`else
  assign collide = 1'b0;
`endif
endmodule

// File: tb/tb_flappy_vga_renderer.sv
// Bench for flappy_vga_renderer: a shrunken-timing instance checked every cycle against a frame-level model,
// plus a default-parameter instance used to pin the real 640x480 line timing.
module tb_flappy_vga_renderer;
  localparam int D = 2, NP = 2, BH = 3, PHW = 4, GH = 5;
  localparam int HA = 32, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 24, VFP = 2, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int LATCH = VA * HT;
`ifdef FLAPPY_COLLIDE_EN
  localparam bit COL_ON = 1'b1;
`else
  localparam bit COL_ON = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]      bx;
    logic [9:0]      by;
    logic [NP*10-1:0] px;
    logic [NP*10-1:0] gy;
    logic [NP-1:0]   en;
  } shadow_t;

  logic clk = 1'b0, rst = 1'b1, rst_full = 1'b1;
  logic [9:0] bird_x, bird_y;
  logic [NP*10-1:0] pipe_x, gap_y;
  logic [NP-1:0] pipe_en;
  logic vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b, frame_start, collide;
  logic full_hs, full_vs, full_r, full_g, full_b, full_fs, full_col;

  int checks = 0, errors = 0;
  int c = 0, last_latch = -1, n_latch = 0;
  bit mvalid = 0, mflag = 0, mcol = 0;
  shadow_t cur = '0, prv = '0;

  always #5 clk = ~clk;

  flappy_vga_renderer #(
    .CLK_DIV(D), .COORD_W(10), .N_PIPES(NP), .BIRD_HALF(BH), .PIPE_HALF_W(PHW), .GAP_HALF(GH),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) u_dut (
    .ClkPort(clk), .reset(rst), .bird_x(bird_x), .bird_y(bird_y), .pipe_x(pipe_x), .gap_y(gap_y),
    .pipe_en(pipe_en), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .frame_start(frame_start), .collide(collide)
  );

  flappy_vga_renderer u_full (
    .ClkPort(clk), .reset(rst_full), .bird_x(10'd0), .bird_y(10'd0), .pipe_x(40'd0), .gap_y(40'd0),
    .pipe_en(4'd0), .vga_h_sync(full_hs), .vga_v_sync(full_vs), .vga_r(full_r), .vga_g(full_g),
    .vga_b(full_b), .frame_start(full_fs), .collide(full_col)
  );

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // Returns {visible, bird covers pixel, some enabled pipe covers pixel} for raster index p.
  function automatic logic [2:0] classify(input int p, input shadow_t s);
    int h, v, px, gy;
    bit vis, bh, ph;
    h = p % HT;
    v = p / HT;
    vis = (h < HA) && (v < VA);
    bh = (iabs(h - int'(s.bx)) <= BH) && (iabs(v - int'(s.by)) <= BH);
    ph = 1'b0;
    for (int i = 0; i < NP; i++) begin
      px = int'(s.px[i*10 +: 10]);
      gy = int'(s.gy[i*10 +: 10]);
      if (s.en[i] && iabs(h - px) <= PHW && (v < gy - GH || v > gy + GH)) ph = 1'b1;
    end
    return {vis, bh, ph};
  endfunction

  // Model: counts clocks since reset; every D-th clock moves the raster one pixel.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      c = 0; cur = '0; prv = '0; last_latch = -1; mflag = 0; mcol = 0; mvalid = 1;
    end else begin
      int q, p;
      logic [2:0] k;
      c++;
      if (c % D == 0) begin
        q = c / D - 1;
        p = q % FRAME;
        k = classify(p, cur);
        if (k == 3'b111) mflag = 1;
        if (p == LATCH) begin
          mcol = mflag; mflag = 0; prv = cur;
          cur = {bird_x, bird_y, pipe_x, gap_y, pipe_en};
          last_latch = q; n_latch++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      int n, q;
      logic [2:0] k;
      logic [6:0] exp_v, got_v;
      logic er, eg, eb, ehs, evs, efs;
      n = c / D;
      er = 0; eg = 0; eb = 0; ehs = 1; evs = 1;
      if (n >= 2) begin
        q = n - 2;
        k = classify(q % FRAME, (q > last_latch) ? cur : prv);
        er = k[2] & k[1];
        eg = k[2] & k[0];
        eb = k[2] & ~(k[1] | k[0]);
        ehs = !(((q % FRAME) % HT) >= HA + HFP && ((q % FRAME) % HT) < HA + HFP + HSY);
        evs = !(((q % FRAME) / HT) >= VA + VFP && ((q % FRAME) / HT) < VA + VFP + VSY);
      end
      efs = (c % D == D - 1) && (n % FRAME == LATCH);
      exp_v = {ehs, evs, er, eg, eb, efs, mcol & COL_ON};
      got_v = {vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b, frame_start, collide};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t hs,vs,r,g,b,fs,col got %b expected %b", $time, got_v, exp_v);
      end
    end
  end

  task automatic wait_latch();
    int k0, t;
    k0 = n_latch; t = 0;
    while (n_latch == k0 && t < FRAME * D + 16) begin
      @(negedge clk); t++;
    end
    if (n_latch == k0) begin
      checks++; errors++;
      $display("FAIL wait_latch timeout after %0d cycles", t);
    end
  endtask

  task automatic check_pix(input string nm, input int h, input int v, input logic [2:0] rgb);
    int t, tgt;
    bit ok;
    t = 0; ok = 0; tgt = v * HT + h;
    while (!ok && t < 2 * FRAME * D + 16) begin
      @(negedge clk); t++;
      if (c / D >= 2 && ((c / D - 2) % FRAME) == tgt) ok = 1;
    end
    checks++;
    if (!ok || {vga_r, vga_g, vga_b} !== rgb) begin
      errors++;
      $display("FAIL %s (%0d,%0d) rgb got %b expected %b reached=%0d", nm, h, v, {vga_r, vga_g, vga_b}, rgb, ok);
    end
  endtask

  task automatic check_col(input string nm, input logic e);
    checks++;
    if (collide !== e) begin
      errors++;
      $display("FAIL %s collide got %b expected %b", nm, collide, e);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return vga_h_sync;
      1:       return vga_v_sync;
      default: return full_hs;
    endcase
  endfunction

  task automatic measure(input string nm, input int s, input int exp_low, input int exp_per, input int bound);
    int t, low, per;
    t = 0; low = 0;
    while (sig(s) !== 1'b1 && t < bound) begin @(negedge clk); t++; end
    while (sig(s) !== 1'b0 && t < bound) begin @(negedge clk); t++; end
    while (sig(s) === 1'b0 && t < bound) begin @(negedge clk); low++; t++; end
    per = low;
    while (sig(s) !== 1'b0 && t < bound) begin @(negedge clk); per++; t++; end
    checks += 2;
    if (low != exp_low) begin errors++; $display("FAIL %s low width got %0d expected %0d", nm, low, exp_low); end
    if (per != exp_per) begin errors++; $display("FAIL %s period got %0d expected %0d", nm, per, exp_per); end
  endtask

  initial begin
    bird_x = 10'd10; bird_y = 10'd10; pipe_x = '0; gap_y = '0; pipe_en = '0;
    repeat (3) @(negedge clk);
    rst = 0; rst_full = 0;

    measure("full_hsync", 2, 96 * 4, 800 * 4, 9000);
    measure("hsync", 0, HSY * D, HT * D, 3 * HT * D);
    measure("vsync", 1, VSY * HT * D, FRAME * D, 3 * FRAME * D);

    wait_latch();
    check_pix("bird_top", 10, 7, 3'b100);
    check_pix("sky_left", 6, 10, 3'b001);
    check_pix("bird_left", 7, 10, 3'b100);
    check_pix("bird_right", 13, 10, 3'b100);
    check_pix("sky_right", 14, 10, 3'b001);
    check_pix("hblank", 36, 10, 3'b000);
    bird_x = 10'd25;
    check_pix("midframe_old", 10, 13, 3'b100);
    check_pix("midframe_new_absent", 25, 13, 3'b001);
    check_pix("vblank", 10, 26, 3'b000);
    wait_latch();
    check_pix("moved_old", 10, 13, 3'b001);
    check_pix("moved_new", 25, 13, 3'b100);

    bird_x = 10'd20; bird_y = 10'd2; pipe_en = 2'b11;
    pipe_x = {10'd28, 10'd2}; gap_y = {10'd10, 10'd15};
    wait_latch();
    check_pix("pipe0_col0", 0, 0, 3'b010);
    check_pix("bird_row0", 20, 0, 3'b100);
    check_pix("bird_edge", 23, 0, 3'b100);
    check_pix("pipe1_left", 24, 0, 3'b010);
    check_pix("pipe1_right", 31, 2, 3'b010);
    check_pix("pipe0_l", 0, 3, 3'b010);
    check_pix("pipe0_r", 6, 3, 3'b010);
    check_pix("pipe0_out", 7, 3, 3'b001);
    check_pix("pipe1_top_end", 24, 4, 3'b010);
    check_pix("pipe1_gap", 24, 5, 3'b001);
    check_pix("bird_below", 20, 6, 3'b001);
    check_pix("pipe0_top_end", 0, 9, 3'b010);
    check_pix("pipe0_gap_top", 0, 10, 3'b001);
    check_pix("pipe1_bottom", 24, 16, 3'b010);
    check_pix("pipe0_gap_bot", 0, 20, 3'b001);
    check_pix("pipe0_bottom", 0, 21, 3'b010);

    bird_x = 10'd5; bird_y = 10'd3; pipe_en = 2'b01;
    wait_latch();
    check_pix("pipe1_off", 28, 0, 3'b001);
    check_pix("yellow", 5, 3, 3'b110);
    wait_latch();
    check_col("col_set", COL_ON);
    bird_y = 10'd15;
    wait_latch();
    check_col("col_hold", COL_ON);
    check_pix("bird_in_gap", 5, 15, 3'b100);
    wait_latch();
    check_col("col_clear", 1'b0);

    bird_y = 10'd3;
    wait_latch();
    wait_latch();
    check_col("col_again", COL_ON);
    check_pix("pre_reset", 5, 3, 3'b110);
    rst = 1;
    @(negedge clk);
    check_col("col_reset", 1'b0);
    checks++;
    if ({vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b, frame_start} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_outs got %b expected 110000", {vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b, frame_start});
    end
    rst = 0;
    check_pix("reset_shadow_bird", 0, 0, 3'b100);
    check_pix("reset_shadow_sky", 4, 0, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
